bus_uart_tx: RTL and testbench
==============================

Name: bus_uart_tx

Overview:
Downstream consumer of the 8-bit bus_out stream produced by the processing blackbox stage.
- Accepts one byte per valid/ready handshake and serialises it on a single line as a UART-style frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between the 8-bit datapath and the board pin or serial-link model.

Parameters:
DATA_W, 8, data byte width; fixed at 8 for this design, kept as a parameter for frame-length arithmetic.
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 1..65535.

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
data_in  input  8  byte to transmit (driven from upstream bus_out)
data_valid  input  1  upstream asserts when data_in holds a byte
data_ready  output  1  high when the block can accept a byte
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: tx=1, data_ready=1, busy=0, frame_done=0, state=IDLE, bit counter=0, timer=0, shift register=0.
- Reset is sampled on the clock edge; asserting rst mid-frame aborts the frame. On the next cycle tx=1, state=IDLE, and no frame_done pulse is generated.
- FSM states: IDLE, START, DATA, STOP.
- data_ready = (state==IDLE). It is a combinational decode of the registered state.
- Handshake:
  - A byte is accepted on the rising edge where data_valid && data_ready.
  - data_in is captured into the shift register at that edge.
  - Later changes to data_in are ignored.
  - data_valid without data_ready has no effect; upstream must hold the byte.
- Transitions:
  - IDLE->START on accept.
  - START->DATA after CLKS_PER_BIT cycles.
  - DATA->STOP after 8 bits, each lasting CLKS_PER_BIT cycles.
  - STOP->IDLE after CLKS_PER_BIT cycles.
- tx is registered:
  - First start-bit cycle is the cycle after the accept edge.
  - START drives 0.
  - DATA drives shift_reg[0], then shifts right by one at each bit boundary.
  - STOP and IDLE drive 1.
- busy = (state != IDLE).
- frame_done is high exactly on the final cycle of STOP. The following cycle is IDLE with data_ready=1.
- Frame length: 10*CLKS_PER_BIT cycles of START/DATA/STOP.
- Back-to-back: with data_valid held high, the next byte is accepted in the first IDLE cycle. The line therefore stays high for CLKS_PER_BIT+1 cycles between start bits.
- Timer:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Width is $clog2(CLKS_PER_BIT+1), minimum 1.
  - With CLKS_PER_BIT=1, every cycle is a bit boundary.
- Bit counter: 3 bits, counts 0..7 in DATA, wraps to 0 on the DATA->STOP transition.
- No X propagation: tx must be 1 whenever state is IDLE, regardless of data_in.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - localparams START_BIT=1'b0, STOP_BIT=1'b1, FRAME_BITS=10.
- One sub-module, uart_bit_timer:
  - parameter CLKS_PER_BIT;
  - inputs clk, rst, en;
  - output bit_tick, a one-cycle pulse when the count reaches CLKS_PER_BIT-1, with the counter cleared when en=0.
- The FSM and shift register stay in bus_uart_tx.

Test Plan:
- CLKS_PER_BIT=4, rst released, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each level for exactly 4 cycles. frame_done pulses on cycle 40 after accept; data_ready is low for cycles 1..40.
- Back-to-back 0x00 then 0xFF with data_valid held -> first frame all-zero data; tx high for 5 cycles (stop + 1 idle); second frame data bits all 1. Exactly 2 frame_done pulses.
- Change data_in from 0x3C to 0xC3 one cycle after accept -> serialised bits are those of 0x3C (0,0,1,1,1,1,0,0).
- rst asserted at cycle 15 of a 0x55 frame -> next cycle tx=1, busy=0, data_ready=1; no frame_done. A following byte 0x81 transmits correctly.
- CLKS_PER_BIT=1, send 0x01 -> 10-cycle frame 0,1,0,0,0,0,0,0,0,1; frame_done on cycle 10.
- data_valid low for 50 cycles after reset -> tx stays 1, busy 0, frame_done never asserts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the byte-to-serial UART transmitter: FSM encodings
// and the fixed frame-level constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clock cycles within one serial bit and pulses
// bit_tick on the last cycle of each bit. Held cleared while en is low.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int CNT_W = ($clog2(CLKS_PER_BIT + 1) < 1) ? 1 : $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Wrap at the bit boundary so the next bit starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_tick = en && (count == LAST_COUNT);

endmodule

// File: rtl/bus_uart_tx.sv
// Byte-stream to UART serialiser: accepts one byte per valid/ready handshake
// and sends start bit, 8 data bits LSB first, then stop bit.
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  tx_state_t         state;
  tx_state_t         state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_cnt_next;
  logic              tx_next;
  logic              bit_tick;
  logic              accept;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .bit_tick(bit_tick)
  );

  assign data_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && bit_tick;
  assign accept     = data_valid && data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tx        <= STOP_BIT;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      tx        <= tx_next;
    end
  end

  // tx is computed from the next state so the registered line level lines up
  // with the state it belongs to.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    tx_next      = STOP_BIT;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
          shift_next = data_in;
          tx_next    = START_BIT;
        end
      end
      START: begin
        tx_next = START_BIT;
        if (bit_tick) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (bit_tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_next   = STOP;
            bit_cnt_next = '0;
            tx_next      = STOP_BIT;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
          end
        end
      end
      STOP: begin
        tx_next = STOP_BIT;
        if (bit_tick) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx: one instance at 4 clocks/bit, one at 1.
module tb_bus_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in4;
  logic       data_valid4;
  logic       data_ready4;
  logic       tx4;
  logic       busy4;
  logic       frame_done4;
  logic [7:0] data_in1;
  logic       data_valid1;
  logic       data_ready1;
  logic       tx1;
  logic       busy1;
  logic       frame_done1;

  int tests;
  int failed;
  int fd4;

  bus_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in4), .data_valid(data_valid4),
    .data_ready(data_ready4), .tx(tx4), .busy(busy4), .frame_done(frame_done4)
  );

  bus_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in1), .data_valid(data_valid1),
    .data_ready(data_ready1), .tx(tx1), .busy(busy1), .frame_done(frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done4) fd4 <= fd4 + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic frameBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Caller has already presented the byte; the first edge here is the accept.
  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] next_data,
                               input logic next_valid, input string tag);
    for (int c = 1; c <= 40; c++) begin
      nextCycle();
      if (c == 1) begin
        data_in4    = next_data;
        data_valid4 = next_valid;
      end
      checkOutput({tag, "_tx"}, 32'(tx4), 32'(frameBit(b, (c - 1) / 4)));
      checkOutput({tag, "_ready"}, 32'(data_ready4), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy4), 32'd1);
      checkOutput({tag, "_done"}, 32'(frame_done4), 32'(c == 40));
    end
    nextCycle();
    checkOutput({tag, "_idle_tx"}, 32'(tx4), 32'd1);
    checkOutput({tag, "_idle_ready"}, 32'(data_ready4), 32'd1);
    checkOutput({tag, "_idle_busy"}, 32'(busy4), 32'd0);
    checkOutput({tag, "_idle_done"}, 32'(frame_done4), 32'd0);
  endtask

  initial begin
    int fd_before;
    tests       = 0;
    failed      = 0;
    fd4         = 0;
    rst         = 1'b1;
    data_in4    = 8'h00;
    data_valid4 = 1'b0;
    data_in1    = 8'h00;
    data_valid1 = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rst_tx", 32'(tx4), 32'd1);
    checkOutput("rst_ready", 32'(data_ready4), 32'd1);
    checkOutput("rst_busy", 32'(busy4), 32'd0);
    checkOutput("rst_done", 32'(frame_done4), 32'd0);
    checkOutput("rst_tx1", 32'(tx1), 32'd1);
    checkOutput("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;

    // Idle line with changing data_in and no valid
    for (int c = 0; c < 50; c++) begin
      data_in4 = 8'($urandom);
      nextCycle();
      checkOutput("idle_tx", 32'(tx4), 32'd1);
      checkOutput("idle_busy", 32'(busy4), 32'd0);
      checkOutput("idle_done", 32'(frame_done4), 32'd0);
    end

    data_in4    = 8'hA5;
    data_valid4 = 1'b1;
    applyStimulus(8'hA5, 8'h00, 1'b0, "a5");

    fd_before   = fd4;
    data_in4    = 8'h00;
    data_valid4 = 1'b1;
    applyStimulus(8'h00, 8'hFF, 1'b1, "b2b00");
    applyStimulus(8'hFF, 8'h00, 1'b0, "b2bff");
    checkOutput("b2b_pulses", 32'(fd4 - fd_before), 32'd2);

    data_in4    = 8'h3C;
    data_valid4 = 1'b1;
    applyStimulus(8'h3C, 8'hC3, 1'b0, "hold3c");

    // Abort a 0x55 frame with reset at cycle 15
    fd_before   = fd4;
    data_in4    = 8'h55;
    data_valid4 = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      nextCycle();
      if (c == 1) data_valid4 = 1'b0;
      checkOutput("abort_tx", 32'(tx4), 32'(frameBit(8'h55, (c - 1) / 4)));
    end
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("abort_tx_idle", 32'(tx4), 32'd1);
    checkOutput("abort_busy", 32'(busy4), 32'd0);
    checkOutput("abort_ready", 32'(data_ready4), 32'd1);
    for (int c = 0; c < 45; c++) nextCycle();
    checkOutput("abort_no_done", 32'(fd4 - fd_before), 32'd0);
    checkOutput("abort_line_high", 32'(tx4), 32'd1);

    data_in4    = 8'h81;
    data_valid4 = 1'b1;
    applyStimulus(8'h81, 8'h00, 1'b0, "after81");

    // One clock per bit
    data_in1    = 8'h01;
    data_valid1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      nextCycle();
      if (c == 1) data_valid1 = 1'b0;
      checkOutput("cpb1_tx", 32'(tx1), 32'(frameBit(8'h01, c - 1)));
      checkOutput("cpb1_done", 32'(frame_done1), 32'(c == 10));
      checkOutput("cpb1_busy", 32'(busy1), 32'd1);
    end
    nextCycle();
    checkOutput("cpb1_idle_ready", 32'(data_ready1), 32'd1);
    checkOutput("cpb1_idle_tx", 32'(tx1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
